// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder: multi-digit BCD decoder with time-multiplexed digit scanning.
// A packed BCD word is accepted over a load/ready handshake. It is held in an active
// register and scanned one digit at a time. Each digit is shown for DIV cycles as a
// one-hot decimal decode plus a one-hot digit select. A value loaded mid-frame waits
// in a shadow register and swaps in at the next frame wrap, so a frame is never torn.
// Optional feature: define BCD_SCAN_BLANK_LZ_EN for leading-zero blanking.
module bcd_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int DIV    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                enable,
    output logic                ready,
    output logic [9:0]          out,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                invalid,
    output logic                frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Architectural state
    state_t              r_state;
    logic [4*DIGITS-1:0] r_active;
    logic [4*DIGITS-1:0] r_shadow;
    logic [IDX_W-1:0]    r_idx;
    logic [DIV_W-1:0]    r_div;
    logic                r_ready;

    // Registered outputs
    logic [9:0]          r_out;
    logic [DIGITS-1:0]   r_sel;
    logic                r_invalid;
    logic                r_frame_done;

    // Next-state values
    logic                w_accept;
    logic                w_div_last;
    logic                w_frame_end;
    state_t              w_state_n;
    logic [4*DIGITS-1:0] w_active_n;
    logic [4*DIGITS-1:0] w_shadow_n;
    logic [IDX_W-1:0]    w_idx_n;
    logic [DIV_W-1:0]    w_div_n;
    logic                w_ready_n;

    // Next output values, derived from the next state so outputs track the held digit
    logic                w_show_n;
    logic [3:0]          w_digit_n;
    logic                w_blank_n;
    logic [9:0]          w_out_n;
    logic [DIGITS-1:0]   w_sel_n;
    logic                w_invalid_n;
    logic                w_frame_done_n;

    // Extract the 4-bit digit at position idx from a packed word
    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] word,
                                            input logic [IDX_W-1:0]    idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                d = word[4*i +: 4];
            end
        end
        return d;
    endfunction

    // One-hot decimal decode; codes 10-15 decode to all zeros
    function automatic logic [9:0] decode_onehot(input logic [3:0] d);
        logic [9:0] o;
        o = '0;
        for (int i = 0; i < 10; i++) begin
            o[i] = (d == 4'(i));
        end
        return o;
    endfunction

    // One-hot digit select for the given index
    function automatic logic [DIGITS-1:0] select_onehot(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] s;
        s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s[i] = (IDX_W'(i) == idx);
        end
        return s;
    endfunction

`ifdef BCD_SCAN_BLANK_LZ_EN
    // A digit above the highest nonzero digit is a leading zero; digit 0 never is,
    // and codes 10-15 count as nonzero
    function automatic logic is_blanked(input logic [4*DIGITS-1:0] word,
                                        input logic [IDX_W-1:0]    idx);
        int hi;
        hi = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (word[4*i +: 4] != 4'd0) begin
                hi = i;
            end
        end
        return (int'(idx) > hi);
    endfunction
`endif

    // Handshake, scan counters and double-buffer transfer for the coming edge
    always_comb begin
        w_accept    = load && r_ready;
        w_div_last  = (r_div == LAST_DIV);
        w_frame_end = (r_state == S_SCAN) && enable && w_div_last && (r_idx == LAST_IDX);

        w_state_n  = r_state;
        w_active_n = r_active;
        w_shadow_n = r_shadow;
        w_idx_n    = r_idx;
        w_div_n    = r_div;
        w_ready_n  = r_ready;

        case (r_state)
            S_IDLE: begin
                // First value goes straight to active; the shadow stays free
                if (w_accept) begin
                    w_state_n  = S_SCAN;
                    w_active_n = bcd_in;
                    w_idx_n    = '0;
                    w_div_n    = '0;
                end
            end
            S_SCAN: begin
                // Divider and index only move while enabled
                if (enable) begin
                    if (w_div_last) begin
                        w_div_n = '0;
                        w_idx_n = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                    end else begin
                        w_div_n = r_div + DIV_W'(1);
                    end
                end
                if (w_frame_end) begin
                    // Pending shadow swaps in at the wrap; with the shadow free,
                    // a load on this edge bypasses it
                    if (!r_ready) begin
                        w_active_n = r_shadow;
                        w_ready_n  = 1'b1;
                    end else if (w_accept) begin
                        w_active_n = bcd_in;
                    end
                end else if (w_accept) begin
                    w_shadow_n = bcd_in;
                    w_ready_n  = 1'b0;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Output decode computed from the state that will be held after the edge
    always_comb begin
        w_show_n  = (w_state_n == S_SCAN) && enable;
        w_digit_n = digit_at(w_active_n, w_idx_n);
`ifdef BCD_SCAN_BLANK_LZ_EN
        w_blank_n = is_blanked(w_active_n, w_idx_n);
`else
        w_blank_n = 1'b0;
`endif
        w_out_n        = (w_show_n && !w_blank_n) ? decode_onehot(w_digit_n) : '0;
        w_sel_n        = w_show_n ? select_onehot(w_idx_n) : '0;
        w_invalid_n    = w_show_n && (w_digit_n > 4'd9);
        w_frame_done_n = w_frame_end;
    end

    // State machine, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_active     <= '0;
            r_shadow     <= '0;
            r_idx        <= '0;
            r_div        <= '0;
            r_ready      <= 1'b1;
            r_out        <= '0;
            r_sel        <= '0;
            r_invalid    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_active     <= w_active_n;
            r_shadow     <= w_shadow_n;
            r_idx        <= w_idx_n;
            r_div        <= w_div_n;
            r_ready      <= w_ready_n;
            r_out        <= w_out_n;
            r_sel        <= w_sel_n;
            r_invalid    <= w_invalid_n;
            r_frame_done <= w_frame_done_n;
        end
    end

    assign ready      = r_ready;
    assign out        = r_out;
    assign digit_sel  = r_sel;
    assign invalid    = r_invalid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Testbench for bcd_scan_decoder with DIGITS=4, DIV=2.
// A frame-position reference model predicts every registered output.
module tb_bcd_scan_decoder;

    localparam int DIGITS_P = 4;
    localparam int DIV_P    = 2;
    localparam int FRAME    = DIGITS_P * DIV_P;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        enable;
    logic        ready;
    logic [9:0]  out;
    logic [3:0]  digit_sel;
    logic        invalid;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: scanning flag, buffers, position within the frame
    bit          m_scan;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;
    int          m_pos;

    // Expected outputs for the current cycle
    logic [9:0]  e_out;
    logic [3:0]  e_sel;
    logic        e_inv;
    logic        e_fd;
    logic        e_rdy;

    bcd_scan_decoder #(.DIGITS(DIGITS_P), .DIV(DIV_P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .enable     (enable),
        .ready      (ready),
        .out        (out),
        .digit_sel  (digit_sel),
        .invalid    (invalid),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_scan    = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 0;
        m_pos     = 0;
        e_out = '0; e_sel = '0; e_inv = 1'b0; e_fd = 1'b0; e_rdy = 1'b1;
    endtask

    // Advance the model by one clock edge with the inputs sampled on it
    task automatic model_edge(input logic ld, input logic [15:0] bcd, input logic en);
        bit acc;
        bit wrap;
        int idx;
        logic [3:0] d;
        bit blank;
        acc  = ld && !m_pending;
        e_fd = 1'b0;
        if (!m_scan) begin
            if (acc) begin
                m_scan   = 1;
                m_active = bcd;
                m_pos    = 0;
            end
        end else begin
            wrap = en && (m_pos == FRAME - 1);
            if (en) m_pos = (m_pos + 1) % FRAME;
            if (wrap) begin
                e_fd = 1'b1;
                if (m_pending) begin
                    m_active  = m_shadow;
                    m_pending = 0;
                end else if (acc) begin
                    m_active = bcd;
                end
            end else if (acc) begin
                m_shadow  = bcd;
                m_pending = 1;
            end
        end
        idx = m_pos / DIV_P;
        d   = 4'((m_active >> (4 * idx)) & 16'hF);
`ifdef BCD_SCAN_BLANK_LZ_EN
        blank = (idx > 0) && ((m_active >> (4 * idx)) == 16'h0);
`else
        blank = 0;
`endif
        if (m_scan && en) begin
            e_sel = 4'(1 << idx);
            e_inv = (d > 9);
            e_out = (d <= 9 && !blank) ? 10'(1 << d) : 10'h000;
        end else begin
            e_sel = '0;
            e_inv = 1'b0;
            e_out = '0;
        end
        e_rdy = !m_pending;
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, settle
    task automatic tick(input logic ld, input logic [15:0] bcd, input logic en);
        load   = ld;
        bcd_in = bcd;
        enable = en;
        @(posedge clk);
        model_edge(ld, bcd, en);
        #1;
    endtask

    task automatic do_reset();
        load = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load = 1'b0; bcd_in = '0; enable = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        if ({out, digit_sel, invalid, frame_done, ready} !== {10'h000, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: out=%h sel=%b inv=%b fd=%b rdy=%b, required 000 0000 0 0 1",
                     out, digit_sel, invalid, frame_done, ready);
        end
        checks++;
        @(posedge clk); #1;
        if ({out, digit_sel, invalid, frame_done, ready} !== {10'h000, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_held: out=%h sel=%b inv=%b fd=%b rdy=%b, required 000 0000 0 0 1",
                     out, digit_sel, invalid, frame_done, ready);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        // Idle with no load: outputs stay dark
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 16'h5555, 1'b1);
            if ({out, digit_sel, invalid, frame_done, ready} !== {10'h000, 4'h0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL idle_dark: out=%h sel=%b inv=%b fd=%b rdy=%b, required 000 0000 0 0 1",
                         out, digit_sel, invalid, frame_done, ready);
            end
            checks++;
        end
    endtask

    task automatic test_basic_scan();
        logic [9:0] tbl [4];
        tbl[0] = 10'h010; tbl[1] = 10'h008; tbl[2] = 10'h004; tbl[3] = 10'h002;
        tick(1'b1, 16'h1234, 1'b1);
        for (int k = 0; k <= FRAME; k++) begin
            if (k > 0) tick(1'b0, 16'h0000, 1'b1);
            if (k < FRAME) begin
                if ({out, digit_sel, frame_done, ready} !== {tbl[k / 2], 4'(1 << (k / 2)), 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL basic_scan[%0d]: out=%h sel=%b fd=%b rdy=%b, required %h %b 0 1",
                             k, out, digit_sel, frame_done, ready, tbl[k / 2], 4'(1 << (k / 2)));
                end
            end else begin
                if ({out, digit_sel, frame_done} !== {10'h010, 4'b0001, 1'b1}) begin
                    errors++;
                    $display("FAIL basic_wrap: out=%h sel=%b fd=%b, required 010 0001 1",
                             out, digit_sel, frame_done);
                end
            end
            checks++;
        end
    endtask

    task automatic test_shadow();
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b1, 16'h9870, 1'b1);
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL shadow_ready_drop: ready=%b, required 0", ready);
        end
        checks++;
        for (int k = 0; k < 14; k++) begin
            tick(1'b0, 16'h0000, 1'b1);
            if ({out, digit_sel, invalid, frame_done, ready} !== {e_out, e_sel, e_inv, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL shadow_scan[%0d]: got out=%h sel=%b inv=%b fd=%b rdy=%b, required %h %b %b %b %b",
                         k, out, digit_sel, invalid, frame_done, ready, e_out, e_sel, e_inv, e_fd, e_rdy);
            end
            checks++;
        end
    endtask

    task automatic test_invalid();
        logic [9:0] x_out [4];
        logic       x_inv [4];
        do_reset();
        x_out[0] = 10'h020; x_inv[0] = 1'b0;
        x_out[1] = 10'h000; x_inv[1] = 1'b1;
`ifdef BCD_SCAN_BLANK_LZ_EN
        x_out[2] = 10'h000; x_out[3] = 10'h000;
`else
        x_out[2] = 10'h001; x_out[3] = 10'h001;
`endif
        x_inv[2] = 1'b0; x_inv[3] = 1'b0;
        tick(1'b1, 16'h00A5, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick(1'b0, 16'h0000, 1'b1);
            if ({out, invalid, digit_sel} !== {x_out[k / 2], x_inv[k / 2], 4'(1 << (k / 2))}) begin
                errors++;
                $display("FAIL invalid_digit[%0d]: out=%h inv=%b sel=%b, required %h %b %b",
                         k, out, invalid, digit_sel, x_out[k / 2], x_inv[k / 2], 4'(1 << (k / 2)));
            end
            checks++;
        end
    endtask

    task automatic test_enable();
        int fd_seen;
        do_reset();
        tick(1'b1, 16'h4321, 1'b1);
        for (int k = 0; k < 4; k++) tick(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 16'h0000, 1'b0);
            if ({out, digit_sel, invalid} !== {10'h000, 4'h0, 1'b0}) begin
                errors++;
                $display("FAIL enable_off[%0d]: out=%h sel=%b inv=%b, required 000 0000 0", k, out, digit_sel, invalid);
            end
            checks++;
        end
        fd_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 16'h0000, 1'b1);
            if (frame_done === 1'b1) fd_seen++;
            if (k == 0 && digit_sel !== 4'b0100) begin
                errors++;
                $display("FAIL enable_resume_digit2: sel=%b, required 0100", digit_sel);
            end
            if (k == 1 && digit_sel !== 4'b1000) begin
                errors++;
                $display("FAIL enable_resume_digit3: sel=%b, required 1000", digit_sel);
            end
            if (k < 2) checks++;
            if ({out, digit_sel, invalid, frame_done, ready} !== {e_out, e_sel, e_inv, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL enable_model[%0d]: got out=%h sel=%b inv=%b fd=%b rdy=%b, required %h %b %b %b %b",
                         k, out, digit_sel, invalid, frame_done, ready, e_out, e_sel, e_inv, e_fd, e_rdy);
            end
            checks++;
        end
        if (fd_seen != 3) begin
            errors++;
            $display("FAIL enable_fd_count: frame_done pulses=%0d, required 3", fd_seen);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 16'h1234, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b1, 16'h5678, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_pending: ready=%b, required 0", ready);
        end
        checks++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        if ({out, digit_sel, invalid, frame_done, ready} !== {10'h000, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL arst_mid_frame: out=%h sel=%b inv=%b fd=%b rdy=%b, required 000 0000 0 0 1",
                     out, digit_sel, invalid, frame_done, ready);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b0, 16'h0000, 1'b1);
        if ({out, digit_sel, ready} !== {10'h000, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL arst_idle: out=%h sel=%b rdy=%b, required 000 0000 1", out, digit_sel, ready);
        end
        checks++;
        tick(1'b1, 16'h0306, 1'b1);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) tick(1'b0, 16'h0000, 1'b1);
            if ({out, digit_sel, invalid, frame_done, ready} !== {e_out, e_sel, e_inv, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL arst_reload[%0d]: got out=%h sel=%b inv=%b fd=%b rdy=%b, required %h %b %b %b %b",
                         k, out, digit_sel, invalid, frame_done, ready, e_out, e_sel, e_inv, e_fd, e_rdy);
            end
            checks++;
        end
    endtask

    task automatic test_frame_end_load();
        do_reset();
        tick(1'b1, 16'h1234, 1'b1);
        for (int k = 0; k < FRAME - 1; k++) tick(1'b0, 16'h0000, 1'b1);
        tick(1'b1, 16'h4567, 1'b1);
        if ({out, digit_sel, frame_done, ready} !== {10'h080, 4'b0001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL fe_load_first: out=%h sel=%b fd=%b rdy=%b, required 080 0001 1 1",
                     out, digit_sel, frame_done, ready);
        end
        checks++;
        for (int k = 0; k < FRAME; k++) begin
            tick(1'b0, 16'h0000, 1'b1);
            if (ready !== 1'b1 || out !== e_out) begin
                errors++;
                $display("FAIL fe_load_hold[%0d]: rdy=%b out=%h, required 1 %h", k, ready, out, e_out);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic ld, en;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            v  = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h00FF;
                1: v = v & 16'h000F;
                2: v = 16'h0000;
                default: ;
            endcase
            ld = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 7) != 0);
            tick(ld, v, en);
            if ({out, digit_sel, invalid, frame_done, ready} !== {e_out, e_sel, e_inv, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL random[%0d]: got out=%h sel=%b inv=%b fd=%b rdy=%b, required %h %b %b %b %b",
                         k, out, digit_sel, invalid, frame_done, ready, e_out, e_sel, e_inv, e_fd, e_rdy);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_shadow();
        test_invalid();
        test_enable();
        test_async_reset();
        test_frame_end_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_decoder.md
# bcd_scan_decoder

Multi-digit BCD decoder with time-multiplexed digit scanning: the decode-side counterpart of the team's decimal-to-BCD priority encoder. It accepts a packed word of BCD digits over a load/ready handshake, holds it in an active register and scans it one digit at a time. For each digit it drives a one-hot 10-line decimal decode and a one-hot digit select, which suits multiplexed indicator or display drivers. New values are double-buffered so a frame is never torn mid-scan.

## Interface
- `DIGITS`, default 4: number of BCD digits (≥1); digit 0 is `bcd_in[3:0]`.
- `DIV`, default 4: clock cycles each digit is held (≥1).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  request to capture `bcd_in`; accepted on an edge where `load && ready`.
- `bcd_in`  in  4*DIGITS  packed BCD digits.
- `enable`  in  1  scan/output enable.
- `ready`  out  1  shadow buffer free.
- `out`  out  10  one-hot decimal decode of the current digit (`out[d]=1` for value d).
- `digit_sel`  out  DIGITS  one-hot index of the current digit.
- `invalid`  out  1  current digit is 10–15.
- `frame_done`  out  1  one-cycle pulse at each frame wrap.

## Operation
- States:
  - IDLE: no value has been loaded since reset.
  - SCAN: a value is active.
- Reset (async, `rst_n`=0) clears everything:
  - state=IDLE, all outputs 0, `ready`=1, active and shadow registers 0, digit index 0, divider 0.
- IDLE:
  - `out`, `digit_sel`, `invalid` and `frame_done` are 0.
  - An accepted load writes `bcd_in` directly to active and moves to SCAN with index 0 and divider 0. `ready` stays 1.
- SCAN, accepted load:
  - `bcd_in` goes to shadow; pending=1; `ready`=0 from the next cycle.
- SCAN, frame end (last digit and divider = DIV−1, with `enable`=1):
  - Index wraps to 0 and the divider clears.
  - If pending, shadow moves to active, pending clears and `ready` returns to 1 on the same edge.
  - If a load is accepted on the frame-end edge while `ready`=1, `bcd_in` goes straight to active and pending stays 0.
- Decode:
  - Digit values 0–9 give one-hot `out` and `invalid`=0.
  - Digit values 10–15 give `out`=0 and `invalid`=1.
- `enable`=0:
  - `out`, `digit_sel` and `invalid` are forced to 0.
  - Divider and index freeze; no frame end can occur.
  - Loads are still accepted into shadow, or into active when in IDLE.
- When `enable` returns to 1, scanning resumes from the frozen index and divider.
- `load` while `ready`=0 is ignored; the upstream block holds the data.

## Timing
- All outputs are registered and update on the same edge as the index and divider, so they always reflect the digit currently held.
- IDLE load at edge t: `digit_sel`=1, and `out` reflects digit 0, from cycle t+1.
- Each digit is driven for exactly DIV cycles; a full frame is DIGITS×DIV cycles.
- `frame_done` is high for exactly one cycle: the first cycle of each new frame, coincident with index 0.
  - It is not asserted on the initial IDLE→SCAN entry.
- A shadowed value becomes visible on the first cycle of the next frame.
- DIV=1: the index advances every cycle.
- DIGITS=1: every DIV-th cycle is a frame end.

## Configuration
- `BCD_SCAN_BLANK_LZ_EN` defined: leading-zero blanking.
  - A digit above the highest nonzero digit of the active word drives `out`=0.
  - `digit_sel` and `invalid` (which is 0 for such a digit) are unaffected.
  - Digit 0 is never blanked.
  - Digit codes 10–15 count as nonzero.
- Macro undefined: every digit is decoded; a 0 gives `out`=10'b0000000001.

## Test plan
DIGITS=4, DIV=2 throughout.
- Reset, then load 16'h1234 with `enable`=1 → for 2 cycles each:
  - `digit_sel`=0001, `out`=10'h010
  - then 0010, `out`=10'h008
  - then 0100, `out`=10'h004
  - then 1000, `out`=10'h002
  - then `frame_done` pulses with `digit_sel`=0001.
- During SCAN of 16'h1234, load 16'h9870 on digit 1 → `ready`=0 next cycle.
  - Digits 2–3 still show 2 and 1.
  - The next frame shows 0, 7, 8, 9 (`out`=10'h001, 10'h080, 10'h100, 10'h200).
  - `ready`=1 from the wrap edge.
- Load 16'h00A5 → digit 0 gives `out`=10'h020, `invalid`=0; digit 1 gives `out`=0, `invalid`=1.
  - With `BCD_SCAN_BLANK_LZ_EN` defined: digits 2–3 give `out`=0.
  - Without it: digits 2–3 give `out`=10'h001.
- Drop `enable` for 5 cycles mid-digit-2 → `out` and `digit_sel` are 0.
  - When `enable` returns, digit 2 completes its remaining divider count and no extra `frame_done` is produced.
- Assert `rst_n`=0 asynchronously mid-frame with pending=1 → all outputs go 0 immediately, `ready`=1, state IDLE, shadow discarded.
- Load on the frame-end edge with `ready`=1 → the new value shows from index 0 of the next frame and `ready` never drops.
